// File: rtl/hash_sched.sv
// Hash-word scheduler: sequences SHAKE output words into address-generator phases per job.
// Optional `HASH_SCHED_PAUSE_EN adds a pause input that stalls word acceptance in RUN.
module hash_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [1:0]  level,
   input  logic        abort,
`ifdef HASH_SCHED_PAUSE_EN
   input  logic        pause,
`endif
   input  logic        shake_valid,
   output logic        shake_ready,
   output logic        agu_addr_clr,
   output logic        agu_add_en,
   output logic [2:0]  agu_mode,
   output logic [1:0]  agu_level,
   output logic [2:0]  phase,
   output logic [13:0] word_cnt,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   localparam logic [2:0] PH_S   = 3'b000;
   localparam logic [2:0] PH_SP  = 3'b001;
   localparam logic [2:0] PH_E   = 3'b010;
   localparam logic [2:0] PH_EP  = 3'b011;
   localparam logic [2:0] PH_EPP = 3'b100;
   localparam logic [2:0] PH_B   = 3'b101;
   localparam logic [2:0] PH_BP  = 3'b110;

   state_t      state;
   logic [1:0]  op_lat;
   logic        hold;
   logic        run_ok;
   logic        last_word;
   logic [2:0]  nxt_phase;

   function automatic logic [2:0] first_phase(input logic [1:0] o);
      case (o)
         2'b00:   first_phase = PH_S;
         2'b01:   first_phase = PH_SP;
         2'b10:   first_phase = PH_B;
         2'b11:   first_phase = PH_BP;
         default: first_phase = PH_S;
      endcase
   endfunction

   function automatic logic [2:0] mode_of(input logic [2:0] ph);
      case (ph)
         PH_S, PH_SP: mode_of = 3'b000;
         PH_E, PH_EP: mode_of = 3'b010;
         PH_EPP:      mode_of = 3'b001;
         PH_B:        mode_of = 3'b100;
         PH_BP:       mode_of = 3'b101;
         default:     mode_of = 3'b000;
      endcase
   endfunction

   // 8 words per loop iteration; E'' is a fixed 64-word phase
   function automatic logic [13:0] len_of(input logic [2:0] ph, input logic [1:0] lvl);
      if (ph == PH_EPP) begin
         len_of = 14'd64;
      end else begin
         case (lvl)
            2'b01:   len_of = 14'd10752;
            2'b10:   len_of = 14'd7808;
            2'b11:   len_of = 14'd5120;
            default: len_of = 14'd0;
         endcase
      end
   endfunction

   function automatic logic [2:0] next_of(input logic [2:0] ph);
      case (ph)
         PH_S:    next_of = PH_E;
         PH_SP:   next_of = PH_EP;
         PH_EP:   next_of = PH_EPP;
         default: next_of = 3'b111;
      endcase
   endfunction

   function automatic logic is_final(input logic [1:0] o, input logic [2:0] ph);
      case (o)
         2'b00:   is_final = (ph == PH_E);
         2'b01:   is_final = (ph == PH_EPP);
         default: is_final = 1'b1;
      endcase
   endfunction

   // Handshake and strobe decode; abort blocks acceptance in its own cycle
   always_comb begin
      hold = 1'b0;
`ifdef HASH_SCHED_PAUSE_EN
      hold = pause;
`endif
      run_ok       = !rst && (state == RUN) && !abort && !hold;
      shake_ready  = run_ok;
      agu_add_en   = run_ok && shake_valid;
      agu_addr_clr = !rst && ((state == CLR) || (abort && (state != IDLE)));
      busy         = !rst && (state != IDLE);
      done         = !rst && (state == DONE) && !abort;
      last_word    = (word_cnt == (len_of(phase, agu_level) - 14'd1));
      nxt_phase    = next_of(phase);
   end

   // Job sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= 3'b000;
         word_cnt  <= 14'd0;
         agu_mode  <= 3'b000;
         agu_level <= 2'b00;
         op_lat    <= 2'b00;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (abort && (state != IDLE)) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (level == 2'b00) begin
                        err <= 1'b1;
                     end else begin
                        op_lat    <= op;
                        agu_level <= level;
                        phase     <= first_phase(op);
                        agu_mode  <= mode_of(first_phase(op));
                        word_cnt  <= 14'd0;
                        state     <= CLR;
                     end
                  end
               end
               CLR: begin
                  word_cnt <= 14'd0;
                  state    <= RUN;
               end
               RUN: begin
                  if (agu_add_en) begin
                     word_cnt <= word_cnt + 14'd1;
                     if (last_word) begin
                        if (is_final(op_lat, phase)) begin
                           state <= DONE;
                        end else begin
                           phase    <= nxt_phase;
                           agu_mode <= mode_of(nxt_phase);
                           word_cnt <= 14'd0;
                           state    <= CLR;
                        end
                     end
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
